// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared definitions for the memory responder.
//   - state_t      : responder FSM state encoding
//   - cnt_t        : wait-state counter type (CNT_W bits)
//   - *_DEF        : default values for the responder parameters
//   - addr_valid() : acceptance check for an incoming byte address
package mem_resp_pkg;

    localparam int WAIT_CYCLES_DEF = 2;
    localparam int DEPTH_WORDS_DEF = 256;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    // A request is accepted only for word-aligned addresses inside the array.
    // The limit is 33 bits wide so a full 4 GiB array still compares correctly.
    function automatic logic addr_valid(input logic [31:0] a, input logic [32:0] limit);
        return (a[1:0] == 2'b00) && ({1'b0, a} < limit);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: word storage for the memory responder.
//   clock   : write clock
//   wr_en   : write strobe, sampled on the rising edge
//   wr_addr : word index written
//   wr_data : 32-bit write data
//   rd_addr : word index read
//   rd_data : combinational read data (captured by the parent's register)
// No reset: contents persist across responder resets and start undefined.
module mem_word_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory target with fixed wait states.
//   clock    : system clock, rising edge
//   reset    : asynchronous active-low reset
//   req      : request strobe, sampled only in IDLE
//   we       : 1 = write, 0 = read (sampled with req)
//   addr     : byte address (sampled with req)
//   wdata    : write data (sampled with req)
//   rdata    : registered read data, held until the next successful read
//   ready    : one-cycle completion pulse
//   addr_err : one-cycle pulse with ready for a rejected request
//   busy     : high whenever the FSM is not IDLE
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        addr_err,
    output logic        busy
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam cnt_t        CNT_LOAD   = (WAIT_CYCLES == 0) ? '0 : cnt_t'(WAIT_CYCLES - 1);

    state_t          state;
    state_t          next_state;
    cnt_t            cnt;
    logic            lat_we;
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_wdata;
    logic            accept;
    logic            enter_resp;
    logic            xfer_we;
    logic [AW-1:0]   xfer_idx;
    logic [31:0]     xfer_wdata;
    logic            mem_wr_en;
    logic [31:0]     mem_rdata;

    assign accept     = (state == IDLE) && req;
    // RESP is only ever entered from IDLE or WAIT, so this marks the entering edge.
    assign enter_resp = (next_state == RESP);

    // With WAIT_CYCLES=0 the access happens on the accepting edge itself, so the
    // live inputs must be used instead of the (not yet loaded) latches.
    assign xfer_we    = (state == IDLE) ? we              : lat_we;
    assign xfer_idx   = (state == IDLE) ? addr[AW+1:2]    : lat_idx;
    assign xfer_wdata = (state == IDLE) ? wdata           : lat_wdata;

    // Gating with reset keeps a zero-wait write from landing while reset is held.
    assign mem_wr_en  = enter_resp && xfer_we && reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        ready      = 1'b0;
        addr_err   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (!addr_valid(addr, ADDR_LIMIT)) begin
                        next_state = ERR;
                    end else if (WAIT_CYCLES == 0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                ready      = 1'b1;
                addr_err   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept && (next_state == WAIT)) begin
            cnt <= CNT_LOAD;
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - cnt_t'(1);
        end
    end

    // Request capture; data-only, so no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            lat_we    <= we;
            lat_idx   <= addr[AW+1:2];
            lat_wdata <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (enter_resp && !xfer_we) begin
            rdata <= mem_rdata;
        end
    end

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clock   (clock),
        .wr_en   (mem_wr_en),
        .wr_addr (xfer_idx),
        .wr_data (xfer_wdata),
        .rd_addr (xfer_idx),
        .rd_data (mem_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with WAIT_CYCLES=2
// (dut) and WAIT_CYCLES=0 (dut0), both with DEPTH_WORDS=256.
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ready, addr_err, busy;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [31:0] rdata0;
    logic        ready0, addr_err0, busy0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(256)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .addr_err (addr_err),
        .busy     (busy)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(256)) dut0 (
        .clock    (clock),
        .reset    (reset),
        .req      (req0),
        .we       (we0),
        .addr     (addr0),
        .wdata    (wdata0),
        .rdata    (rdata0),
        .ready    (ready0),
        .addr_err (addr_err0),
        .busy     (busy0)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One transfer on dut. lat = number of cycles from the accepting edge to the
    // cycle in which ready is seen (1 = cycle right after accept); 0 = timeout.
    // Inputs are scrambled right after acceptance to show they are not re-sampled.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic err);
        @(negedge clock);
        req = 1'b1; we = w; addr = a; wdata = d;
        tick();
        req = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; wdata = ~d;
        lat = 0;
        err = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (ready) begin
                lat = n;
                err = addr_err;
                break;
            end
            tick();
        end
        tick();
    endtask

    int          lat;
    logic        err;
    int          accepts;
    int          last_acc;
    int          rd_cnt;
    logic        prev_busy;
    logic [31:0] exp_rd;

    initial begin
        // Reset state, no clock edge needed.
        #2;
        check("rst_rdata",    rdata,            32'h0);
        check("rst_ready",    {31'b0, ready},   32'h0);
        check("rst_addr_err", {31'b0, addr_err},32'h0);
        check("rst_busy",     {31'b0, busy},    32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Write then read 0x10, 3-cycle latency each.
        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, lat, err);
        check("wr10_lat",   lat,            32'd3);
        check("wr10_err",   {31'b0, err},   32'h0);
        check("wr10_rdata", rdata,          32'h0);
        check("wr10_busy",  {31'b0, busy},  32'h0);
        xfer(1'b0, 32'h10, 32'h0, lat, err);
        check("rd10_lat",   lat,            32'd3);
        check("rd10_err",   {31'b0, err},   32'h0);
        check("rd10_rdata", rdata,          32'hDEAD_BEEF);

        // Misaligned read: error one cycle after accept, rdata held.
        xfer(1'b0, 32'h12, 32'h0, lat, err);
        check("rd12_lat",   lat,            32'd1);
        check("rd12_err",   {31'b0, err},   32'h1);
        check("rd12_rdata", rdata,          32'hDEAD_BEEF);

        // Out-of-range read, then the last valid word.
        xfer(1'b0, 32'h400, 32'h0, lat, err);
        check("rd400_lat",  lat,            32'd1);
        check("rd400_err",  {31'b0, err},   32'h1);
        xfer(1'b1, 32'h3FC, 32'h1, lat, err);
        check("wr3fc_lat",  lat,            32'd3);
        check("wr3fc_err",  {31'b0, err},   32'h0);
        xfer(1'b0, 32'h3FC, 32'h0, lat, err);
        check("rd3fc_lat",  lat,            32'd3);
        check("rd3fc_rdata", rdata,         32'h1);

        // Reset mid-WAIT aborts a write to 0x20.
        xfer(1'b1, 32'h20, 32'hA5A5_A5A5, lat, err);
        check("wr20_lat",   lat,            32'd3);
        @(negedge clock);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55;
        tick();
        req = 1'b0; we = 1'b0;
        check("abort_busy_pre", {31'b0, busy}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy",   {31'b0, busy},     32'h0);
        check("abort_ready",  {31'b0, ready},    32'h0);
        check("abort_rdata",  rdata,             32'h0);
        tick();
        check("abort_ready1", {31'b0, ready},    32'h0);
        tick();
        check("abort_ready2", {31'b0, ready},    32'h0);
        @(negedge clock);
        reset = 1'b1;
        xfer(1'b0, 32'h20, 32'h0, lat, err);
        check("rd20_lat",   lat,            32'd3);
        check("rd20_rdata", rdata,          32'hA5A5_A5A5);

        // req held high, alternating 0x10 / 0x3FC reads.
        @(negedge clock);
        req = 1'b1; we = 1'b0; addr = 32'h10;
        accepts   = 0;
        last_acc  = 0;
        rd_cnt    = 0;
        prev_busy = busy;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            tick();
            if (busy && !prev_busy) begin
                accepts++;
                if (accepts > 1) begin
                    check("b2b_spacing", cyc - last_acc, 32'd4);
                end
                last_acc = cyc;
                addr = (addr == 32'h10) ? 32'h3FC : 32'h10;
            end
            if (ready) begin
                exp_rd = (rd_cnt % 2 == 0) ? 32'hDEAD_BEEF : 32'h1;
                check("b2b_rdata", rdata, exp_rd);
                rd_cnt++;
            end
            prev_busy = busy;
        end
        req = 1'b0;
        check("b2b_accepts", accepts, 32'd5);
        check("b2b_readies", rd_cnt,  32'd4);
        repeat (4) tick();

        // Zero-wait instance: write then read word 0.
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h0000_CAFE;
        tick();
        req0 = 1'b0; we0 = 1'b0; wdata0 = '0;
        check("z_wr_ready", {31'b0, ready0},    32'h1);
        check("z_wr_err",   {31'b0, addr_err0}, 32'h0);
        check("z_wr_busy",  {31'b0, busy0},     32'h1);
        tick();
        check("z_wr_idle",  {31'b0, busy0},     32'h0);
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
        tick();
        req0 = 1'b0;
        check("z_rd_ready", {31'b0, ready0},    32'h1);
        check("z_rd_busy",  {31'b0, busy0},     32'h1);
        check("z_rd_rdata", rdata0,             32'h0000_CAFE);
        tick();
        check("z_rd_idle",  {31'b0, busy0},     32'h0);
        check("z_rd_ready0",{31'b0, ready0},    32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of wait states between request acceptance and response (0..15).
REQ-002 Parameter DEPTH_WORDS, default 256, number of 32-bit words of storage (power of two).
REQ-003 clock  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 req  input  1  initiator request strobe; sampled only in IDLE.
REQ-006 we  input  1  1 = word write, 0 = word read; sampled with req.
REQ-007 addr  input  32  byte address; sampled with req.
REQ-008 wdata  input  32  write data; sampled with req.
REQ-009 rdata  output  32  registered read data.
REQ-010 ready  output  1  one-cycle response pulse; transfer complete.
REQ-011 addr_err  output  1  one-cycle pulse, coincident with ready, for a rejected request.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, WAIT, RESP, ERR; encoded as a shared package enum.
REQ-014 IDLE with req=1: latch we/addr/wdata in the same edge; busy rises the next cycle.
REQ-015 Acceptance check: addr[1:0]!=0 or addr >= 4*DEPTH_WORDS -> next state ERR; otherwise WAIT (or RESP directly when WAIT_CYCLES=0).
REQ-016 WAIT: 4-bit counter loaded with WAIT_CYCLES-1 on entry, decrements each cycle; at 0 -> RESP.
REQ-017 Latency: ready is high exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-018 Write: storage word addr[log2(DEPTH_WORDS)+1:2] updated on the edge entering RESP; rdata unchanged.
REQ-019 Read: rdata loaded from storage on the edge entering RESP and held until the next successful read.
REQ-020 RESP: ready=1 and addr_err=0 for one cycle, then IDLE.
REQ-021 ERR: ready=1 and addr_err=1 for one cycle, then IDLE; storage and rdata unchanged.
REQ-022 req outside IDLE is ignored, including in the RESP/ERR cycle; no queuing. Minimum accept-to-accept spacing is WAIT_CYCLES+2 cycles.
REQ-023 Input changes after acceptance do not affect the transfer in progress.
REQ-024 Read of a word never written returns X in simulation; no initialisation is required.

Reset
REQ-025 reset=0 forces IDLE, counter 0, rdata 0, ready 0, addr_err 0, busy 0 immediately, without waiting for clock.
REQ-026 Reset during WAIT aborts the transfer: no storage write occurs and no ready pulse is issued.
REQ-027 Storage contents are not cleared by reset.
REQ-028 The first request is accepted on the first rising edge with reset=1 and req=1.

Structure
REQ-029 Package mem_resp_pkg holds the state enum, the WAIT_CYCLES/DEPTH_WORDS defaults, and the counter width constant (4).
REQ-030 Storage is one sub-module, mem_word_array: one synchronous write port, one read port, no reset.
REQ-031 The FSM, counter, latches and the acceptance check reside in mem_responder.

Verification
REQ-032 WAIT_CYCLES=2: write 0xDEADBEEF to 0x10, then read 0x10 -> each ready pulse occurs 3 cycles after accept; rdata=0xDEADBEEF.
REQ-033 Read 0x12 (misaligned) -> ready=1 and addr_err=1 one cycle after accept; rdata keeps its previous value.
REQ-034 Read 0x400 with DEPTH_WORDS=256 -> addr_err pulse; a following write to 0x3FC with 0x1 succeeds; read back gives 0x1.
REQ-035 Accept a write of 0x55 to 0x20, assert reset=0 mid-WAIT -> busy=0 asynchronously, no ready pulse; a later read of 0x20 returns its old contents.
REQ-036 Hold req=1 continuously with alternating addresses -> accepts exactly every WAIT_CYCLES+2 cycles; none accepted while busy=1.
REQ-037 WAIT_CYCLES=0: read of 0x0 -> ready in the cycle after accept; busy high for exactly 1 cycle.
